systolic_matmul_engine: RTL

//  NxN output-stationary systolic array computing C = A x B over a selectable semiring: boolean OR-AND, saturating MAC, or tropical min-plus.

---
 rtl/sa_pkg.sv | 33 +++
 rtl/sa_pe.sv | 99 +++++++++
 rtl/systolic_matmul_engine.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/sa_pkg.sv
// rtl/sa_pkg.sv - shared types and saturating add for the systolic matmul engine
package sa_pkg;

   localparam int SA_SAT_W = 64;

   typedef enum logic [1:0] {
      SA_OR_AND  = 2'b00,
      SA_MAC     = 2'b01,
      SA_MINPLUS = 2'b10
   } sa_mode_e;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LOAD    = 2'd1,
      DRAIN   = 2'd2,
      READOUT = 2'd3
   } sa_state_e;

   // Returns {saturated, value}; value clamped to 2^w-1, w below SA_SAT_W.
   function automatic logic [SA_SAT_W:0] sat_add(input logic [SA_SAT_W-1:0] x,
                                                 input logic [SA_SAT_W-1:0] y,
                                                 input int w);
      logic [SA_SAT_W:0] sum;
      logic [SA_SAT_W:0] lim;
      sum = {1'b0, x} + {1'b0, y};
      lim = ((SA_SAT_W+1)'(1) << w) - (SA_SAT_W+1)'(1);
      if (sum > lim) begin
         return {1'b1, lim[SA_SAT_W-1:0]};
      end
      return {1'b0, sum[SA_SAT_W-1:0]};
   endfunction

endpackage

// File: rtl/sa_pe.sv
// rtl/sa_pe.sv - one output-stationary PE with semiring select
// SA_TROPICAL_EN adds the min-plus comparator and all-ones accumulator init.
module sa_pe
   import sa_pkg::*;
#(
   parameter int W     = 8,
   parameter int ACC_W = 20
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_clear,
`ifdef SA_TROPICAL_EN
   input  logic             i_init_ones,
`endif
   input  sa_mode_e         i_mode,
   input  logic [W-1:0]     i_a,
   input  logic             i_a_valid,
   input  logic [W-1:0]     i_b,
   input  logic             i_b_valid,
   output logic [W-1:0]     o_a,
   output logic             o_a_valid,
   output logic [W-1:0]     o_b,
   output logic             o_b_valid,
   output logic [ACC_W-1:0] o_acc,
   output logic             o_ovf
);

   logic [W-1:0]      r_a;
   logic [W-1:0]      r_b;
   logic              r_a_valid;
   logic              r_b_valid;
   logic [ACC_W-1:0]  r_acc;

   logic              w_fire;
   logic [2*W-1:0]    w_prod;
   logic [SA_SAT_W:0] w_mac;
   logic [ACC_W-1:0]  w_next;
   logic              w_sat;
`ifdef SA_TROPICAL_EN
   logic [SA_SAT_W:0] w_sum;
`endif

   assign w_fire = i_a_valid & i_b_valid;
   assign w_prod = {{W{1'b0}}, i_a} * {{W{1'b0}}, i_b};

   always_comb begin
      w_next = r_acc;
      w_sat  = 1'b0;
      w_mac  = sat_add(SA_SAT_W'(r_acc), SA_SAT_W'(w_prod), ACC_W);
`ifdef SA_TROPICAL_EN
      w_sum  = sat_add(SA_SAT_W'(i_a), SA_SAT_W'(i_b), ACC_W);
`endif
      case (i_mode)
         SA_OR_AND: w_next = r_acc | ACC_W'(i_a & i_b);
`ifdef SA_TROPICAL_EN
         SA_MINPLUS: begin
            w_sat  = w_sum[SA_SAT_W] | (|w_sum[SA_SAT_W-1:ACC_W]);
            w_next = (w_sum[ACC_W-1:0] < r_acc) ? w_sum[ACC_W-1:0] : r_acc;
         end
`endif
         default: begin
            w_sat  = w_mac[SA_SAT_W] | (|w_mac[SA_SAT_W-1:ACC_W]);
            w_next = w_mac[ACC_W-1:0];
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_a       <= '0;
         r_b       <= '0;
         r_a_valid <= 1'b0;
         r_b_valid <= 1'b0;
         r_acc     <= '0;
      end else begin
         r_a       <= i_a;
         r_b       <= i_b;
         r_a_valid <= i_a_valid;
         r_b_valid <= i_b_valid;
         if (i_clear) begin
`ifdef SA_TROPICAL_EN
            r_acc <= i_init_ones ? '1 : '0;
`else
            r_acc <= '0;
`endif
         end else if (w_fire) begin
            r_acc <= w_next;
         end
      end
   end

   assign o_a       = r_a;
   assign o_b       = r_b;
   assign o_a_valid = r_a_valid;
   assign o_b_valid = r_b_valid;
   assign o_acc     = r_acc;
   assign o_ovf     = w_fire & w_sat;

endmodule

// File: rtl/systolic_matmul_engine.sv
// rtl/systolic_matmul_engine.sv - NxN output-stationary systolic C = A x B engine
// SA_TROPICAL_EN: mode 10 selects min-plus; otherwise mode 10 runs as MAC.
module systolic_matmul_engine
   import sa_pkg::*;
#(
   parameter int N     = 4,
   parameter int W     = 8,
   parameter int ACC_W = 20
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [1:0]         mode,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               in_last,
   input  logic [N*W-1:0]     a_col,
   input  logic [N*W-1:0]     b_row,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               out_last,
   output logic [N*ACC_W-1:0] out_row,
   output logic               busy,
   output logic               overflow
);

   localparam int CNT_W = $clog2(2*N);
   localparam int RW    = (N > 1) ? $clog2(N) : 1;

   sa_state_e          r_state;
   sa_state_e          w_state_next;
   sa_mode_e           r_mode;
   sa_mode_e           w_mode_dec;
   logic [CNT_W-1:0]   r_drain_cnt;
   logic [RW-1:0]      r_row;
   logic               r_out_valid;
   logic               r_out_last;
   logic [N*ACC_W-1:0] r_out_row;
   logic               r_overflow;

   logic               w_accept;
   logic               w_start_ok;
   logic               w_out_fire;
   logic               w_drain_done;
   logic               w_load_row;
   logic [N*ACC_W-1:0] w_row_mux;

   logic [W-1:0]       w_a  [N][N+1];
   logic               w_av [N][N+1];
   logic [W-1:0]       w_b  [N+1][N];
   logic               w_bv [N+1][N];
   logic [ACC_W-1:0]   w_acc [N][N];
   logic [N*N-1:0]     w_ovf;

   assign w_accept     = in_valid & (r_state == LOAD);
   assign w_start_ok   = start & (r_state == IDLE);
   assign w_out_fire   = r_out_valid & out_ready;
   assign w_drain_done = (r_drain_cnt == CNT_W'(2*N-2));
   assign w_load_row   = (r_state == READOUT) & (~r_out_valid | (out_ready & ~r_out_last));

   always_comb begin
      w_mode_dec = SA_MAC;
      case (mode)
         2'b00:   w_mode_dec = SA_OR_AND;
`ifdef SA_TROPICAL_EN
         2'b10:   w_mode_dec = SA_MINPLUS;
`endif
         default: w_mode_dec = SA_MAC;
      endcase
   end

   always_comb begin
      w_state_next = r_state;
      in_ready     = 1'b0;
      busy         = 1'b1;
      case (r_state)
         IDLE: begin
            busy = 1'b0;
            if (start) w_state_next = LOAD;
         end
         LOAD: begin
            in_ready = 1'b1;
            if (w_accept && in_last) w_state_next = DRAIN;
         end
         DRAIN: begin
            if (w_drain_done) w_state_next = READOUT;
         end
         READOUT: begin
            if (w_out_fire && r_out_last) w_state_next = IDLE;
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_row_mux = '0;
      for (int j = 0; j < N; j++) begin
         w_row_mux[j*ACC_W +: ACC_W] = w_acc[r_row][j];
      end
   end

   // r_row names the next row to present; rows are registered so out_row holds under backpressure.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_mode      <= SA_OR_AND;
         r_drain_cnt <= '0;
         r_row       <= '0;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
         r_out_row   <= '0;
         r_overflow  <= 1'b0;
      end else begin
         if (w_start_ok) begin
            r_mode     <= w_mode_dec;
            r_overflow <= 1'b0;
         end else if (|w_ovf) begin
            r_overflow <= 1'b1;
         end

         if (r_state == DRAIN) begin
            r_drain_cnt <= r_drain_cnt + CNT_W'(1);
         end else begin
            r_drain_cnt <= '0;
         end

         if (w_load_row) begin
            r_out_valid <= 1'b1;
            r_out_row   <= w_row_mux;
            r_out_last  <= (r_row == RW'(N-1));
            r_row       <= r_row + RW'(1);
         end else if (w_out_fire && r_out_last) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_row       <= '0;
         end
      end
   end

   genvar gi, gj;
   generate
      for (gi = 0; gi < N; gi++) begin : g_skew
         if (gi == 0) begin : g_direct
            assign w_a[0][0]  = a_col[0 +: W];
            assign w_av[0][0] = w_accept;
            assign w_b[0][0]  = b_row[0 +: W];
            assign w_bv[0][0] = w_accept;
         end else begin : g_delay
            logic [W-1:0] r_a_sk  [gi];
            logic         r_a_skv [gi];
            logic [W-1:0] r_b_sk  [gi];
            logic         r_b_skv [gi];

            always_ff @(posedge clk) begin
               if (reset) begin
                  for (int d = 0; d < gi; d++) begin
                     r_a_sk[d]  <= '0;
                     r_a_skv[d] <= 1'b0;
                     r_b_sk[d]  <= '0;
                     r_b_skv[d] <= 1'b0;
                  end
               end else begin
                  r_a_sk[0]  <= a_col[gi*W +: W];
                  r_a_skv[0] <= w_accept;
                  r_b_sk[0]  <= b_row[gi*W +: W];
                  r_b_skv[0] <= w_accept;
                  for (int d = 1; d < gi; d++) begin
                     r_a_sk[d]  <= r_a_sk[d-1];
                     r_a_skv[d] <= r_a_skv[d-1];
                     r_b_sk[d]  <= r_b_sk[d-1];
                     r_b_skv[d] <= r_b_skv[d-1];
                  end
               end
            end

            assign w_a[gi][0]  = r_a_sk[gi-1];
            assign w_av[gi][0] = r_a_skv[gi-1];
            assign w_b[0][gi]  = r_b_sk[gi-1];
            assign w_bv[0][gi] = r_b_skv[gi-1];
         end
      end

      for (gi = 0; gi < N; gi++) begin : g_row
         for (gj = 0; gj < N; gj++) begin : g_col
            sa_pe #(
               .W     (W),
               .ACC_W (ACC_W)
            ) u_pe (
               .clk         (clk),
               .reset       (reset),
               .i_clear     (w_start_ok),
`ifdef SA_TROPICAL_EN
               .i_init_ones (w_mode_dec == SA_MINPLUS),
`endif
               .i_mode      (r_mode),
               .i_a         (w_a[gi][gj]),
               .i_a_valid   (w_av[gi][gj]),
               .i_b         (w_b[gi][gj]),
               .i_b_valid   (w_bv[gi][gj]),
               .o_a         (w_a[gi][gj+1]),
               .o_a_valid   (w_av[gi][gj+1]),
               .o_b         (w_b[gi+1][gj]),
               .o_b_valid   (w_bv[gi+1][gj]),
               .o_acc       (w_acc[gi][gj]),
               .o_ovf       (w_ovf[gi*N+gj])
            );
         end
      end
   endgenerate

   assign out_valid = r_out_valid;
   assign out_last  = r_out_last;
   assign out_row   = r_out_row;
   assign overflow  = r_overflow;

endmodule
